shift_sequencer: RTL

- Controller that sequences the team's 8-bit shift-register datapath.
- Accepts a start command with load value, shift count and mode.
- Drives the shifter's load, shift and arithmetic-shift controls cycle by cycle, reads back the shifter output, and returns a latched result with a one-cycle done pulse.
- Sits between a requesting FSM (or switch/key front end) and the shifter datapath.

---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_counter.sv | 31 +++
 rtl/shift_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: state encoding and
// default datapath/count widths.
package shift_sequencer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_sequencer_counter.sv
// Loadable down-counter with decrement enable and zero flag; holds the
// remaining shift count for the sequencer.
module shift_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement; decrement stops at zero so it can never wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for the 8-bit shift-register datapath: load, N right shifts
// (logical or arithmetic, pausable by hold), then capture with a done pulse.
//
// state   | meaning
// IDLE    | waiting for start; done pulse shows here after CAPTURE
// LOAD    | shifter loads the latched value
// SHIFT   | one right shift per cycle while hold is low
// CAPTURE | shifter output is registered into result
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [CNT_W-1:0] i_shift_count,
  input  logic             i_arith,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_q_in,
  output logic             o_sh_load,
  output logic             o_sh_shift,
  output logic             o_sh_asr,
  output logic [WIDTH-1:0] o_sh_load_val,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_value;
  logic             r_arith;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic [CNT_W-1:0] w_clamped;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;
  logic             w_accept;
  logic             w_dec;

  assign w_clamped = (i_shift_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : i_shift_count;
  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_dec     = (r_state == ST_SHIFT) && !i_hold;

  shift_counter #(.CNT_W(CNT_W)) u_count (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_accept),
    .i_load_val (w_clamped),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_value  <= '0;
      r_arith  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_CAPTURE);
      if (w_accept) begin
        r_value <= i_load_value;
        r_arith <= i_arith;
      end
      if (r_state == ST_CAPTURE) begin
        r_result <= i_q_in;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_sh_load     = 1'b0;
    o_sh_shift    = 1'b0;
    o_sh_asr      = 1'b0;
    o_sh_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_sh_load     = 1'b1;
        o_sh_load_val = r_value;
        w_next        = w_zero ? ST_CAPTURE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!i_hold) begin
          o_sh_shift = 1'b1;
          o_sh_asr   = r_arith;
          // Last shift leaves when the count is at 1; <= guards an unreachable 0.
          if (w_count <= CNT_W'(1)) w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule
